// File: rtl/xbar_pkg.sv
// Shared helpers for the registered round-robin crossbar.
package xbar_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int onehot_to_bin(input logic [63:0] oh);
    int b;
    b = 0;
    for (int k = 0; k < 64; k++) begin
      if (oh[k]) b = k;
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own rotating pointer; pointer moves past the
// winner only when the owner reports an actual transfer.
module rr_arbiter
  import xbar_pkg::*;
#(
  parameter int REQ_NUM = 16,
  localparam int IW = idx_width(REQ_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REQ_NUM-1:0] req,
  input  logic               advance,
  output logic [REQ_NUM-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  logic [IW-1:0]        ptr;
  logic [IW-1:0]        sel;
  logic                 found;
  logic [REQ_NUM-1:0]   masked;
  logic [2*REQ_NUM-1:0] dbl;

  // Low half keeps only requests at/after ptr; the high half provides the wrap.
  always_comb begin
    masked = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      masked[k] = req[k] & (k >= int'(ptr));
    end
    dbl   = {req, masked};
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < 2*REQ_NUM; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        sel   = IW'(k % REQ_NUM);
      end
    end
    gnt = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      gnt[k] = found && (sel == IW'(k));
    end
  end

  assign gnt_idx = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= IW'((onehot_to_bin(64'(gnt)) + 1) % REQ_NUM);
    end
  end

endmodule

// File: rtl/xbar_rr_reg.sv
// Registered crossbar: per-output round-robin arbitration into a one-entry
// valid/ready output register.
module xbar_rr_reg
  import xbar_pkg::*;
#(
  parameter int INPUT_NUM  = 16,
  parameter int OUTPUT_NUM = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INPUT_NUM-1:0]  i_valid,
  input  logic [OUTPUT_NUM-1:0] i_dest [0:INPUT_NUM-1],
  input  logic [DATA_WIDTH-1:0] i_data [0:INPUT_NUM-1],
  output logic [INPUT_NUM-1:0]  i_ready,
  output logic [OUTPUT_NUM-1:0] o_valid,
  output logic [DATA_WIDTH-1:0] o_data [0:OUTPUT_NUM-1],
  output logic [INPUT_NUM-1:0]  o_src  [0:OUTPUT_NUM-1],
  input  logic [OUTPUT_NUM-1:0] o_ready
);

  localparam int IW = idx_width(INPUT_NUM);

  logic [INPUT_NUM-1:0]  req     [OUTPUT_NUM];
  logic [INPUT_NUM-1:0]  gnt     [OUTPUT_NUM];
  logic [IW-1:0]         gnt_idx [OUTPUT_NUM];
  logic [OUTPUT_NUM-1:0] can_load;
  logic [OUTPUT_NUM-1:0] load;

  always_comb begin
    for (int j = 0; j < OUTPUT_NUM; j++) begin
      req[j] = '0;
      for (int i = 0; i < INPUT_NUM; i++) begin
        req[j][i] = i_valid[i] & i_dest[i][j];
      end
    end
  end

  assign can_load = ~o_valid | o_ready;

  // During reset nothing may be accepted even though the registers read empty.
  always_comb begin
    i_ready = '0;
    load    = '0;
    for (int j = 0; j < OUTPUT_NUM; j++) begin
      load[j] = can_load[j] & (|gnt[j]);
      if (can_load[j]) i_ready = i_ready | gnt[j];
    end
    i_ready = i_ready & {INPUT_NUM{rst_n}};
  end

  for (genvar j = 0; j < OUTPUT_NUM; j++) begin : g_arb
    rr_arbiter #(.REQ_NUM(INPUT_NUM)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req[j]),
      .advance (load[j]),
      .gnt     (gnt[j]),
      .gnt_idx (gnt_idx[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= '0;
      for (int j = 0; j < OUTPUT_NUM; j++) begin
        o_data[j] <= '0;
        o_src[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < OUTPUT_NUM; j++) begin
        if (can_load[j]) begin
          o_valid[j] <= load[j];
          if (load[j]) begin
            o_data[j] <= i_data[gnt_idx[j]];
            o_src[j]  <= gnt[j];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < INPUT_NUM; i++) begin : g_chk
    a_dest_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      i_valid[i] |-> $onehot0(i_dest[i]));
  end

endmodule

// File: tb/tb_xbar_rr_reg.sv
// Randomized and directed checks of xbar_rr_reg against a queue-free
// behavioural model of per-output round-robin with a one-entry register.
module tb_xbar_rr_reg;
  localparam int N = 16;
  localparam int M = 16;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] i_valid;
  logic [M-1:0] i_dest [0:N-1];
  logic [W-1:0] i_data [0:N-1];
  logic [N-1:0] i_ready;
  logic [M-1:0] o_valid;
  logic [W-1:0] o_data [0:M-1];
  logic [N-1:0] o_src  [0:M-1];
  logic [M-1:0] o_ready;

  always #5 clk = ~clk;

  xbar_rr_reg #(.INPUT_NUM(N), .OUTPUT_NUM(M), .DATA_WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_dest  (i_dest),
    .i_data  (i_data),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_src   (o_src),
    .o_ready (o_ready)
  );

  int total = 0;
  int bad   = 0;

  bit           m_valid [M];
  logic [W-1:0] m_data  [M];
  int           m_src   [M];
  int           m_ptr   [M];
  int           win     [M];
  logic [N-1:0] exp_ready;
  logic [N-1:0] last_ready = '0;
  logic [N-1:0] seq_exp [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < M; j++) begin
      m_valid[j] = 1'b0;
      m_data[j]  = '0;
      m_src[j]   = 0;
      m_ptr[j]   = 0;
    end
  endtask

  // Winner for output j = first requesting input scanning upward from ptr with wrap.
  task automatic model_eval();
    exp_ready = '0;
    for (int j = 0; j < M; j++) begin
      win[j] = -1;
      for (int off = 0; off < N; off++) begin
        int i;
        i = (m_ptr[j] + off) % N;
        if (win[j] < 0 && i_valid[i] && i_dest[i][j]) win[j] = i;
      end
      if (win[j] >= 0 && (!m_valid[j] || o_ready[j])) exp_ready[win[j]] = 1'b1;
    end
    if (!rst_n) exp_ready = '0;
  endtask

  task automatic model_clock();
    for (int j = 0; j < M; j++) begin
      if (!m_valid[j] || o_ready[j]) begin
        if (win[j] >= 0) begin
          m_valid[j] = 1'b1;
          m_data[j]  = i_data[win[j]];
          m_src[j]   = win[j];
          m_ptr[j]   = (win[j] + 1) % N;
        end else begin
          m_valid[j] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [M-1:0] ev;
    ev = '0;
    for (int j = 0; j < M; j++) ev[j] = m_valid[j];
    chk("o_valid", 32'(o_valid), 32'(ev));
    for (int j = 0; j < M; j++) begin
      if (m_valid[j]) begin
        logic [N-1:0] s;
        s = '0;
        s[m_src[j]] = 1'b1;
        chk($sformatf("o_data[%0d]", j), 32'(o_data[j]), 32'(m_data[j]));
        chk($sformatf("o_src[%0d]", j), 32'(o_src[j]), 32'(s));
      end
    end
  endtask

  task automatic cycle();
    #1;
    model_eval();
    chk("i_ready", 32'(i_ready), 32'(exp_ready));
    last_ready = i_ready;
    @(posedge clk);
    model_clock();
    #1;
    check_outputs();
  endtask

  task automatic clear_inputs();
    i_valid = '0;
    for (int i = 0; i < N; i++) begin
      i_dest[i] = '0;
      i_data[i] = '0;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    o_ready = '0;
    clear_inputs();
    model_reset();
    i_valid = 16'h0003;
    i_dest[0] = 16'h0001;
    i_dest[1] = 16'h0002;
    #12;
    chk("reset_o_valid", 32'(o_valid), 32'h0);
    chk("reset_i_ready", 32'(i_ready), 32'h0);
    chk("reset_o_data0", 32'(o_data[0]), 32'h0);
    chk("reset_o_src0", 32'(o_src[0]), 32'h0);
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single path: input 2 -> output 7
    o_ready = '1;
    i_valid[2] = 1'b1; i_dest[2] = 16'h0080; i_data[2] = 8'hA5;
    #1 chk("single_ready", 32'(i_ready), 32'h0004);
    cycle();
    chk("single_valid7", 32'(o_valid[7]), 32'h1);
    chk("single_data7", 32'(o_data[7]), 32'hA5);
    chk("single_src7", 32'(o_src[7]), 32'h0004);
    clear_inputs();
    cycle();

    // contention on output 0: order 1,4,9,1,4,9
    seq_exp[0] = 16'h0002; seq_exp[1] = 16'h0010; seq_exp[2] = 16'h0200;
    seq_exp[3] = 16'h0002; seq_exp[4] = 16'h0010; seq_exp[5] = 16'h0200;
    foreach (seq_exp[k]) begin
      i_valid[1] = 1'b1; i_dest[1] = 16'h0001; i_data[1] = 8'h01;
      i_valid[4] = 1'b1; i_dest[4] = 16'h0001; i_data[4] = 8'h04;
      i_valid[9] = 1'b1; i_dest[9] = 16'h0001; i_data[9] = 8'h09;
      cycle();
      chk($sformatf("fair_ready%0d", k), 32'(last_ready), 32'(seq_exp[k]));
      chk($sformatf("fair_src%0d", k), 32'(o_src[0]), 32'(seq_exp[k]));
    end
    clear_inputs();
    cycle();

    // back-pressure on output 5
    o_ready[5] = 1'b0;
    i_valid[8] = 1'b1; i_dest[8] = 16'h0020; i_data[8] = 8'h33;
    cycle();
    clear_inputs();
    chk("bp_fill_valid", 32'(o_valid[5]), 32'h1);
    i_valid[3] = 1'b1; i_dest[3] = 16'h0020; i_data[3] = 8'h77;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("bp_stall_ready3", 32'(last_ready[3]), 32'h0);
      chk("bp_stall_data5", 32'(o_data[5]), 32'h33);
    end
    o_ready[5] = 1'b1;
    cycle();
    chk("bp_release_ready3", 32'(last_ready[3]), 32'h1);
    chk("bp_release_valid5", 32'(o_valid[5]), 32'h1);
    chk("bp_release_data5", 32'(o_data[5]), 32'h77);
    clear_inputs();
    cycle();

    // permutation: input k -> output 15-k
    for (int k = 0; k < N; k++) begin
      i_valid[k] = 1'b1;
      i_dest[k]  = 16'(1) << (15 - k);
      i_data[k]  = W'($urandom);
    end
    #1 chk("perm_ready", 32'(i_ready), 32'hFFFF);
    cycle();
    for (int k = 0; k < N; k++)
      chk($sformatf("perm_data%0d", 15 - k), 32'(o_data[15-k]), 32'(i_data[k]));
    clear_inputs();

    // valid with empty destination
    i_valid[6] = 1'b1; i_dest[6] = '0; i_data[6] = 8'h5A;
    cycle();
    chk("empty_ready6", 32'(last_ready[6]), 32'h0);
    chk("empty_no_output", 32'(o_valid), 32'h0);
    clear_inputs();

    // reset mid-traffic with output 3 held
    o_ready[3] = 1'b0;
    i_valid[1] = 1'b1; i_dest[1] = 16'h0008; i_data[1] = 8'h3C;
    cycle();
    chk("mid_hold3", 32'(o_valid[3]), 32'h1);
    clear_inputs();
    i_valid[0] = 1'b1; i_dest[0] = 16'h0004; i_data[0] = 8'hC0;
    i_valid[5] = 1'b1; i_dest[5] = 16'h0004; i_data[5] = 8'hC5;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'h0);
    chk("mid_rst_ready", 32'(i_ready), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    o_ready = '1;
    cycle();
    chk("post_rst_ready", 32'(last_ready), 32'h0001);
    chk("post_rst_src2", 32'(o_src[2]), 32'h0001);
    i_valid[0] = 1'b0;
    cycle();
    chk("post_rst_src2b", 32'(o_src[2]), 32'h0020);
    clear_inputs();
    cycle();

    // randomized traffic, respecting hold-until-ready
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!i_valid[i] || last_ready[i] || i_dest[i] == '0) begin
          i_valid[i] = ($urandom_range(0, 9) < 6);
          if ($urandom_range(0, 9) == 0) i_dest[i] = '0;
          else if ($urandom_range(0, 1) == 1) i_dest[i] = 16'(1) << $urandom_range(0, 3);
          else i_dest[i] = 16'(1) << $urandom_range(0, 15);
          i_data[i] = W'($urandom);
        end
      end
      for (int j = 0; j < M; j++) o_ready[j] = ($urandom_range(0, 9) < 7);
      if (c == 1500) begin
        rst_n = 1'b0;
        #1;
        chk("rand_rst_valid", 32'(o_valid), 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_ready = '0;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
